// File: rtl/axi_lite_cfg_slave.sv
// AXI4-Lite target for accelerator run-time config registers.
// Adds CTRL (start pulse) and STATUS (busy, sticky done) words.
module axi_lite_cfg_slave #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     AWADDR,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [31:0]           WDATA,
   input  logic [3:0]            WSTRB,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_W-1:0]     ARADDR,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [31:0]           RDATA,
   output logic [1:0]            RRESP,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [NUM_REGS*32-1:0] cfg_regs,
   output logic                  start_pulse,
   input  logic                  busy_in,
   input  logic                  done_in
);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   localparam logic [6:0] CFG_END = 7'(NUM_REGS + 2);

   w_state_t    w_state, w_next;
   r_state_t    r_state, r_next;
   logic        live;
   logic        aw_got, w_got;
   logic [5:0]  aw_idx_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  bresp_q;
   logic        aw_hs, w_hs, ar_hs, commit;
   logic [5:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, rd_val;
   logic [3:0]  wr_strb;
   logic        wr_cfg, wr_ok, rd_cfg, rd_ok;
   logic        done_sticky;
   logic [31:0] cfg_q [NUM_REGS];
   logic        unused_addr;

   assign unused_addr = ^{AWADDR[ADDR_W-1:8], AWADDR[1:0],
                          ARADDR[ADDR_W-1:8], ARADDR[1:0]};

   // Readies held low in reset and for the first edge after it.
   assign AWREADY = live & (w_state == W_IDLE) & ~aw_got;
   assign WREADY  = live & (w_state == W_IDLE) & ~w_got;
   assign ARREADY = live & (r_state == R_IDLE);
   assign aw_hs   = AWVALID & AWREADY;
   assign w_hs    = WVALID & WREADY;
   assign ar_hs   = ARVALID & ARREADY;
   assign BRESP   = bresp_q;

   // The write commits on the edge where the second of AW/W lands.
   assign wr_idx  = aw_got ? aw_idx_q : AWADDR[7:2];
   assign wr_data = w_got ? wdata_q : WDATA;
   assign wr_strb = w_got ? wstrb_q : WSTRB;
   assign wr_cfg  = (wr_idx >= 6'd2) && ({1'b0, wr_idx} < CFG_END);
   assign wr_ok   = (wr_idx < 6'd2) || wr_cfg;
   assign rd_idx  = ARADDR[7:2];
   assign rd_cfg  = (rd_idx >= 6'd2) && ({1'b0, rd_idx} < CFG_END);

   // Write FSM next state and response valid.
   always_comb begin
      w_next = w_state;
      BVALID = 1'b0;
      commit = 1'b0;
      unique case (w_state)
         W_IDLE: begin
            commit = (aw_got | aw_hs) & (w_got | w_hs);
            if (commit) w_next = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) w_next = W_IDLE;
         end
      endcase
   end

   // Read FSM next state and data valid.
   always_comb begin
      r_next = r_state;
      RVALID = 1'b0;
      unique case (r_state)
         R_IDLE: if (ar_hs) r_next = R_DATA;
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY) r_next = R_IDLE;
         end
      endcase
   end

   // FSM state registers and the post-reset ready enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
         live    <= 1'b0;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
         live    <= 1'b1;
      end
   end

   // Capture AW and W independently; clear both on commit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         aw_got   <= 1'b0;
         w_got    <= 1'b0;
         aw_idx_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         bresp_q  <= 2'b00;
      end else if (commit) begin
         aw_got  <= 1'b0;
         w_got   <= 1'b0;
         bresp_q <= wr_ok ? 2'b00 : 2'b10;
      end else begin
         if (aw_hs) begin
            aw_got   <= 1'b1;
            aw_idx_q <= AWADDR[7:2];
         end
         if (w_hs) begin
            w_got   <= 1'b1;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
         end
      end
   end

   // Byte-enabled update of the config registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
      end else if (commit && wr_cfg) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if ({1'b0, wr_idx} == 7'(i + 2)) begin
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) cfg_q[i][8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Start pulse and sticky done; a new done beats a same-cycle clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         start_pulse <= 1'b0;
         done_sticky <= 1'b0;
      end else begin
         start_pulse <= commit && (wr_idx == 6'd0) && wr_strb[0] && wr_data[0];
         if (done_in)
            done_sticky <= 1'b1;
         else if (commit && (wr_idx == 6'd1) && wr_strb[0] && wr_data[1])
            done_sticky <= 1'b0;
      end
   end

   // Read decode against the register contents before any same-edge write.
   always_comb begin
      rd_val = '0;
      rd_ok  = 1'b1;
      unique case (1'b1)
         (rd_idx == 6'd0): rd_val = '0;
         (rd_idx == 6'd1): rd_val = {30'b0, done_sticky, busy_in};
         rd_cfg: begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if ({1'b0, rd_idx} == 7'(i + 2)) rd_val = cfg_q[i];
            end
         end
         default: rd_ok = 1'b0;
      endcase
   end

   // Register read data and response at the AR handshake.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         RDATA <= '0;
         RRESP <= 2'b00;
      end else if (ar_hs) begin
         RDATA <= rd_val;
         RRESP <= rd_ok ? 2'b00 : 2'b10;
      end
   end

   // Flatten the config registers for the datapath.
   always_comb begin
      cfg_regs = '0;
      for (int i = 0; i < NUM_REGS; i++) cfg_regs[32*i +: 32] = cfg_q[i];
   end

endmodule
